wrapper_packet_fifo: RTL and testbench

- Synchronous first-word-fall-through FIFO holding whole accelerator packets (data plus last flag).
- Sits directly downstream of the packet constructor and upstream of the accelerator input.
- Decouples register-write packet assembly from accelerator back-pressure, so several packets can be written before the engine accepts any.
- Provides occupancy and almost-full status for the wrapper's control logic.

---
 rtl/wrapper_packet_fifo.sv | 116 +++++++++++
 tb/tb_wrapper_packet_fifo.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wrapper_packet_fifo.sv
// wrapper_packet_fifo
//   First-word-fall-through FIFO of whole accelerator packets ({last, data}).
//   It sits between the packet constructor and the accelerator input, so the
//   register-write side can queue packets while the engine is back-pressuring.
//   Optional feature macro: WRAPPER_PACKET_FIFO_STATS_EN enables saturating
//   16-bit push/pop beat counters. When it is undefined, both stat ports are
//   tied to zero.
module wrapper_packet_fifo #(
  parameter int PACKETWIDTH = 512,
  parameter int DEPTH       = 4,
  parameter int AFULL_LEVEL = 3
) (
  input  logic                       hclk,
  input  logic                       hreset,
  input  logic                       flush,
  input  logic [PACKETWIDTH-1:0]     in_packet_data,
  input  logic                       in_packet_data_last,
  input  logic                       in_packet_data_valid,
  output logic                       in_packet_data_ready,
  output logic [PACKETWIDTH-1:0]     out_packet_data,
  output logic                       out_packet_data_last,
  output logic                       out_packet_data_valid,
  input  logic                       out_packet_data_ready,
  output logic [$clog2(DEPTH):0]     occupancy,
  output logic                       almost_full,
  output logic [15:0]                stat_in_count,
  output logic [15:0]                stat_out_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C = CW'(AFULL_LEVEL);

  logic [PACKETWIDTH:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 push, pop;

  // Handshakes and status are all derived from the registered count.
  assign in_packet_data_ready  = (count_q != FULL_C);
  assign out_packet_data_valid = (count_q != '0);
  assign push                  = in_packet_data_valid & in_packet_data_ready;
  assign pop                   = out_packet_data_valid & out_packet_data_ready;
  assign occupancy             = count_q;
  assign almost_full           = (count_q >= AFULL_C);

  // Head entry falls through combinationally from the read pointer.
  assign out_packet_data_last  = mem_q[rd_ptr_q][PACKETWIDTH];
  assign out_packet_data       = mem_q[rd_ptr_q][PACKETWIDTH-1:0];

  // Next-state pointers and count; flush discards contents and any handshake.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register; only the pointers and count are reset.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Packet storage; a write while flushing is harmless since the pointers clear.
  always_ff @(posedge hclk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_packet_data_last, in_packet_data};
    end
  end

`ifdef WRAPPER_PACKET_FIFO_STATS_EN
  logic [15:0] stat_in_q;
  logic [15:0] stat_out_q;

  // Saturating beat counters; flushed handshakes are not counted, and only
  // reset clears the counters.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      stat_in_q  <= '0;
      stat_out_q <= '0;
    end else if (!flush) begin
      if (push && (stat_in_q != 16'hFFFF))  stat_in_q  <= stat_in_q + 16'd1;
      if (pop  && (stat_out_q != 16'hFFFF)) stat_out_q <= stat_out_q + 16'd1;
    end
  end

  assign stat_in_count  = stat_in_q;
  assign stat_out_count = stat_out_q;
`else
  assign stat_in_count  = 16'h0;
  assign stat_out_count = 16'h0;
`endif

endmodule

// File: tb/tb_wrapper_packet_fifo.sv
// Self-checking bench for wrapper_packet_fifo: a queue-based reference model,
// a per-cycle compare process, directed scenarios with literal expectations,
// and a randomized phase. Respects WRAPPER_PACKET_FIFO_STATS_EN if defined.
module tb_wrapper_packet_fifo;

  localparam int PW    = 512;
  localparam int DEPTH = 4;
  localparam int AFULL = 3;
  localparam int OW    = $clog2(DEPTH) + 1;

  logic          hclk = 1'b0;
  logic          hreset, flush;
  logic [PW-1:0] in_data;
  logic          in_last, in_valid, in_ready;
  logic [PW-1:0] out_data;
  logic          out_last, out_valid, out_ready;
  logic [OW-1:0] occupancy;
  logic          almost_full;
  logic [15:0]   stat_in, stat_out;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [PW:0] q [$];
  int          m_sin, m_sout;
  bit          armed = 1'b0;

  wrapper_packet_fifo #(.PACKETWIDTH(PW), .DEPTH(DEPTH), .AFULL_LEVEL(AFULL)) dut (
    .hclk(hclk), .hreset(hreset), .flush(flush),
    .in_packet_data(in_data), .in_packet_data_last(in_last),
    .in_packet_data_valid(in_valid), .in_packet_data_ready(in_ready),
    .out_packet_data(out_data), .out_packet_data_last(out_last),
    .out_packet_data_valid(out_valid), .out_packet_data_ready(out_ready),
    .occupancy(occupancy), .almost_full(almost_full),
    .stat_in_count(stat_in), .stat_out_count(stat_out)
  );

  always #5 hclk = ~hclk;

  task automatic chk(input string name, input logic [PW+7:0] act, input logic [PW+7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int sat_inc(input int v);
    return (v >= 16'hFFFF) ? 16'hFFFF : v + 1;
  endfunction

  // Reference model: advance on every rising edge from the sampled inputs.
  always @(posedge hclk) begin
    bit p_push, p_pop;
    if (hreset) begin
      q.delete();
      m_sin  = 0;
      m_sout = 0;
      armed  = 1'b1;
    end else if (armed) begin
      p_push = in_valid && (q.size() < DEPTH);
      p_pop  = out_ready && (q.size() > 0);
      if (flush) begin
        q.delete();
      end else begin
`ifdef WRAPPER_PACKET_FIFO_STATS_EN
        if (p_push) m_sin  = sat_inc(m_sin);
        if (p_pop)  m_sout = sat_inc(m_sout);
`endif
        if (p_pop)  void'(q.pop_front());
        if (p_push) q.push_back({in_last, in_data});
      end
    end
  end

  // Compare DUT against the model on every falling edge once reset has been seen.
  always @(negedge hclk) begin
    if (armed) begin
      chk("in_ready",    in_ready,    q.size() != DEPTH);
      chk("out_valid",   out_valid,   q.size() != 0);
      chk("occupancy",   occupancy,   q.size());
      chk("almost_full", almost_full, q.size() >= AFULL);
      chk("stat_in",     stat_in,     m_sin);
      chk("stat_out",    stat_out,    m_sout);
      if (q.size() != 0) chk("head", {out_last, out_data}, q[0]);
    end
  end

  task automatic step();
    @(posedge hclk);
    #1;
  endtask

  function automatic logic [PW-1:0] rnd_data();
    logic [PW-1:0] d;
    for (int i = 0; i < PW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  initial begin
    hreset = 1'b1; flush = 1'b0;
    in_data = '0; in_last = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    // Reset then idle
    step(); step();
    hreset = 1'b0;
    chk("rst_ready", in_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_occ",   occupancy, 0);
    chk("rst_af",    almost_full, 0);
    chk("rst_sin",   stat_in, 0);
    chk("rst_sout",  stat_out, 0);

    // Fill with back-pressure
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = PW'(i); in_last = (i == 4);
      step();
      if (i == 2) chk("af_at2", almost_full, 0);
      if (i == 3) chk("af_at3", almost_full, 1);
    end
    chk("full_occ",   occupancy, 4);
    chk("full_ready", in_ready, 0);
    in_data = PW'(5); in_last = 1'b0;
    step(); step();
    chk("held_occ",  occupancy, 4);
    chk("held_head", out_data, 1);
    in_valid = 1'b0;

    // Drain in order
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_data", out_data, i);
      chk("drain_last", out_last, i == 4);
      step();
      if (i == 1) chk("ready_back", in_ready, 1);
    end
    chk("empty_valid", out_valid, 0);
    chk("empty_occ",   occupancy, 0);

    // Steady occupancy of two with simultaneous push/pop and pointer wrap
    out_ready = 1'b0; in_valid = 1'b1; in_last = 1'b0;
    in_data = PW'('h10); step();
    in_data = PW'('h11); step();
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      in_data = PW'('h12 + k);
      chk("pp_head", out_data, 'h10 + k);
      step();
      chk("pp_occ", occupancy, 2);
    end
    in_valid = 1'b0;
    step(); step();
    chk("pp_empty", out_valid, 0);

    // Flush versus push
    out_ready = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin in_data = PW'('h20 + k); step(); end
    chk("pre_flush_occ", occupancy, 3);
    flush = 1'b1; in_data = PW'('hAA);
    step();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    chk("flush_occ",   occupancy, 0);
    chk("flush_valid", out_valid, 0);
    step(); step();
    chk("flush_noAA", out_valid, 0);

    // Randomized traffic with occasional flush and reset
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      in_data   = rnd_data();
      in_last   = $urandom_range(0, 1);
      flush     = ($urandom_range(0, 99) == 0);
      hreset    = ($urandom_range(0, 299) == 0);
      step();
    end
    flush = 1'b0; hreset = 1'b0;

    // Saturating stats: continuous stream, then flush, then reset
    in_valid = 1'b1; out_ready = 1'b1;
`ifdef WRAPPER_PACKET_FIFO_STATS_EN
    for (int c = 0; c < 70000; c++) begin in_data = PW'(c); step(); end
`else
    for (int c = 0; c < 200; c++) begin in_data = PW'(c); step(); end
`endif
    in_valid = 1'b0;
    step();
`ifdef WRAPPER_PACKET_FIFO_STATS_EN
    chk("sat_in",  stat_in,  16'hFFFF);
    chk("sat_out", stat_out, 16'hFFFF);
`else
    chk("off_in",  stat_in,  0);
    chk("off_out", stat_out, 0);
`endif
    flush = 1'b1; step(); flush = 1'b0;
`ifdef WRAPPER_PACKET_FIFO_STATS_EN
    chk("flush_keep_in",  stat_in,  16'hFFFF);
    chk("flush_keep_out", stat_out, 16'hFFFF);
`endif
    hreset = 1'b1; step(); hreset = 1'b0;
    chk("rst_clr_in",  stat_in,  0);
    chk("rst_clr_out", stat_out, 0);
    chk("rst_clr_occ", occupancy, 0);
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
